// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor, one CW-bit ripple segment per stage, global-stall handshake.
// Define RCA_PIPE_OVF_EN to add the registered signed-overflow output `ovf`.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef RCA_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = WIDTH / STAGES;

    logic advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet summed: this stage's chunk plus every chunk above it.
        localparam int RW = WIDTH - k * CW;

        logic [RW-1:0]         src_a;
        logic [RW-1:0]         src_b;
        logic                  src_c;
        logic                  src_v;
        logic [CW:0]           chunk_s;
        logic [(k+1)*CW-1:0]   sum_new;
        logic                  valid_d, valid_q;
        logic                  carry_d, carry_q;
        logic [(k+1)*CW-1:0]   sum_d, sum_q;

        if (k == 0) begin : g_src
            always_comb begin
                src_a   = a;
                src_b   = b ^ {WIDTH{sub}};
                src_c   = cin ^ sub;
                src_v   = in_valid;
                sum_new = chunk_s[CW-1:0];
            end
        end else begin : g_src
            always_comb begin
                src_a   = g_stage[k-1].g_fwd.a_q;
                src_b   = g_stage[k-1].g_fwd.b_q;
                src_c   = g_stage[k-1].carry_q;
                src_v   = g_stage[k-1].valid_q;
                sum_new = {chunk_s[CW-1:0], g_stage[k-1].sum_q};
            end
        end

        always_comb begin
            chunk_s = {1'b0, src_a[CW-1:0]} + {1'b0, src_b[CW-1:0]} + {{CW{1'b0}}, src_c};
        end

        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (advance) begin
                valid_d = src_v;
                carry_d = chunk_s[CW];
                sum_d   = sum_new;
            end else begin
                valid_d = valid_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Upper operand chunks ride along, skewed one register per stage.
        if (k < STAGES - 1) begin : g_fwd
            logic [RW-CW-1:0] a_d, a_q;
            logic [RW-CW-1:0] b_d, b_q;

            always_comb begin
                if (advance) begin
                    a_d = src_a[RW-1:CW];
                    b_d = src_b[RW-1:CW];
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef RCA_PIPE_OVF_EN
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d, ovf_q;

            always_comb begin
                if (advance) begin
                    ovf_d = src_a[CW-1] ^ src_b[CW-1] ^ chunk_s[CW-1] ^ chunk_s[CW];
                end else begin
                    ovf_d = ovf_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

`ifdef RCA_PIPE_OVF_EN
    assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
